// File: rtl/control_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package control_pkg;

    typedef enum logic [1:0] {
        HZ_RUN    = 2'd0,
        HZ_MDWAIT = 2'd1,
        HZ_ERR    = 2'd2
    } hz_state_e;

    localparam int unsigned MD_TIMEOUT = 63;
    localparam int unsigned WD_W       = 6;

    // x0 is hardwired zero, so it can never carry a dependency.
    function automatic logic src_match(input logic [4:0] rd, input logic [4:0] rs, input logic used);
        return used && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage fields in, enables/bubbles/status out.
interface hazard_ctrl_if;
    import control_pkg::*;

    logic [4:0] if_id_rs1;
    logic [4:0] if_id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       id_is_branch;
    logic [4:0] id_ex_rd;
    logic       id_ex_reg_write;
    logic       id_ex_mem_read;
    logic [4:0] ex_mem_rd;
    logic       ex_mem_mem_read;
    logic       ex_muldiv;
    logic       muldiv_done;
    logic       br_taken;

    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        ex_mem_bubble;
    hz_state_e   state;
    logic        error;
    logic [15:0] stall_cnt;

    modport master (
        output if_id_rs1, if_id_rs2, id_uses_rs1, id_uses_rs2, id_is_branch,
               id_ex_rd, id_ex_reg_write, id_ex_mem_read, ex_mem_rd, ex_mem_mem_read,
               ex_muldiv, muldiv_done, br_taken,
        input  pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_bubble, ex_mem_bubble,
               state, error, stall_cnt
    );

    modport slave (
        input  if_id_rs1, if_id_rs2, id_uses_rs1, id_uses_rs2, id_is_branch,
               id_ex_rd, id_ex_reg_write, id_ex_mem_read, ex_mem_rd, ex_mem_mem_read,
               ex_muldiv, muldiv_done, br_taken,
        output pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_bubble, ex_mem_bubble,
               state, error, stall_cnt
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use and branch-operand dependency detection for the ID stage.
module hazard_detect
    import control_pkg::*;
(
    input  logic [4:0] if_id_rs1,
    input  logic [4:0] if_id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       id_is_branch,
    input  logic [4:0] id_ex_rd,
    input  logic       id_ex_reg_write,
    input  logic       id_ex_mem_read,
    input  logic [4:0] ex_mem_rd,
    input  logic       ex_mem_mem_read,
    output logic       lu,
    output logic       bx,
    output logic       bl
);

    logic [1:0][4:0] src_rs;
    logic [1:0]      src_used;
    logic [1:0]      ex_hit;
    logic [1:0]      mem_hit;

    assign src_rs   = {if_id_rs2, if_id_rs1};
    assign src_used = {id_uses_rs2, id_uses_rs1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign ex_hit[gi]  = src_match(id_ex_rd,  src_rs[gi], src_used[gi]);
            assign mem_hit[gi] = src_match(ex_mem_rd, src_rs[gi], src_used[gi]);
        end
    endgenerate

    assign lu = id_ex_mem_read & (|ex_hit);
    assign bx = id_is_branch & id_ex_reg_write & (|ex_hit);
    assign bl = id_is_branch & ex_mem_mem_read & (|mem_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: data-hazard stalls, multi-cycle MUL/DIV hold with
// watchdog, and a saturating stall counter.
module hazard_ctrl
    import control_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);

    hz_state_e       state_reg, state_next;
    logic [WD_W-1:0] wd_reg, wd_next;
    logic            error_reg;
    logic [15:0]     stall_cnt_reg;

    logic lu, bx, bl, data_hz;
    logic pc_en, if_id_en, id_ex_en, id_ex_bubble, ex_mem_bubble;

    hazard_detect u_detect (
        .if_id_rs1       (hz.if_id_rs1),
        .if_id_rs2       (hz.if_id_rs2),
        .id_uses_rs1     (hz.id_uses_rs1),
        .id_uses_rs2     (hz.id_uses_rs2),
        .id_is_branch    (hz.id_is_branch),
        .id_ex_rd        (hz.id_ex_rd),
        .id_ex_reg_write (hz.id_ex_reg_write),
        .id_ex_mem_read  (hz.id_ex_mem_read),
        .ex_mem_rd       (hz.ex_mem_rd),
        .ex_mem_mem_read (hz.ex_mem_mem_read),
        .lu              (lu),
        .bx              (bx),
        .bl              (bl)
    );

    assign data_hz = lu | bx | bl;

    always_comb begin
        state_next    = state_reg;
        wd_next       = wd_reg;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        unique case (state_reg)
            HZ_RUN: begin
                // The MUL/DIV hold freezes the whole front end, so data hazards are moot.
                if (hz.ex_muldiv && !hz.muldiv_done) begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_bubble = 1'b1;
                    state_next    = HZ_MDWAIT;
                    wd_next       = '0;
                end else if (data_hz) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
            HZ_MDWAIT: begin
                if (hz.muldiv_done) begin
                    state_next = HZ_RUN;
                end else begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_bubble = 1'b1;
                    if (wd_reg == WD_W'(MD_TIMEOUT)) begin
                        state_next = HZ_ERR;
                    end else begin
                        wd_next = wd_reg + 1'b1;
                    end
                end
            end
            HZ_ERR: begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
                id_ex_en = 1'b0;
            end
            default: state_next = HZ_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= HZ_RUN;
            wd_reg        <= '0;
            error_reg     <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            wd_reg    <= wd_next;
            if (state_next == HZ_ERR) begin
                error_reg <= 1'b1;
            end
            if (!pc_en && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
        end
    end

    // A taken branch seen during a stall is dropped; ID presents it again once released.
    assign hz.if_id_flush   = hz.br_taken & pc_en;
    assign hz.pc_en         = pc_en;
    assign hz.if_id_en      = if_id_en;
    assign hz.id_ex_en      = id_ex_en;
    assign hz.id_ex_bubble  = id_ex_bubble;
    assign hz.ex_mem_bubble = ex_mem_bubble;
    assign hz.state         = state_reg;
    assign hz.error         = error_reg;
    assign hz.stall_cnt     = stall_cnt_reg;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 if_id_rs1, if_id_rs2  input  5  source registers of instruction in ID.
REQ-005 id_uses_rs1, id_uses_rs2  input  1  ID instruction actually reads rs1/rs2.
REQ-006 id_is_branch  input  1  ID holds branch/JALR, compared in ID.
REQ-007 id_ex_rd  input  5; id_ex_reg_write  input  1; id_ex_mem_read  input  1  EX-stage destination/control.
REQ-008 ex_mem_rd  input  5; ex_mem_mem_read  input  1  MEM-stage destination/control.
REQ-009 ex_muldiv  input  1  EX holds multi-cycle MUL/DIV op; muldiv_done  input  1  unit result valid this cycle.
REQ-010 br_taken  input  1  branch resolved taken in ID.
REQ-011 pc_en, if_id_en, id_ex_en  output  1  register enables (1 = advance).
REQ-012 if_id_flush, id_ex_bubble, ex_mem_bubble  output  1  insert NOP into that register.
REQ-013 state  output  hz_state_e  current FSM state; error  output  1  sticky muldiv timeout.
REQ-014 stall_cnt  output  16  saturating count of cycles with pc_en=0.

Function
REQ-015 SHALL define hazards (rd!=0 in all): LU = id_ex_mem_read & id_ex_rd matches a used ID source; BX = id_is_branch & id_ex_reg_write & id_ex_rd matches a used source; BL = id_is_branch & ex_mem_mem_read & ex_mem_rd matches a used source.
REQ-016 FSM states SHALL be HZ_RUN, HZ_MDWAIT, HZ_ERR; reset state HZ_RUN.
REQ-017 In HZ_RUN with LU|BX|BL: pc_en=0, if_id_en=0, id_ex_bubble=1, id_ex_en=1 for exactly that cycle; re-evaluated every cycle (BL after LU yields 2 total stall cycles).
REQ-018 In HZ_RUN with ex_muldiv=1 & muldiv_done=0: pc_en=if_id_en=id_ex_en=0, ex_mem_bubble=1, id_ex_bubble=0; next state HZ_MDWAIT, watchdog cleared to 0.
REQ-019 In HZ_RUN with ex_muldiv=1 & muldiv_done=1: no stall, remain HZ_RUN.
REQ-020 In HZ_MDWAIT: same hold outputs as REQ-018 while muldiv_done=0; watchdog increments each cycle; on muldiv_done=1 all enables =1, bubbles =0 that cycle, next HZ_RUN.
REQ-021 Muldiv hold SHALL take priority over LU/BX/BL; data hazards ignored while holding.
REQ-022 If watchdog reaches 63 in HZ_MDWAIT without done: next HZ_ERR; error=1 from that edge until reset.
REQ-023 HZ_ERR: pc_en=if_id_en=id_ex_en=0, all bubbles 0, no exit except reset.
REQ-024 if_id_flush = br_taken & pc_en (taken branch ignored during any stall, re-presented by ID).
REQ-025 All enable/bubble/flush outputs SHALL be combinational from state and inputs (zero latency).
REQ-026 stall_cnt SHALL increment on each edge where pc_en=0, holding at 16'hFFFF.

Reset
REQ-027 On rst_n=0 (any cycle, incl. mid-HZ_MDWAIT): state=HZ_RUN, watchdog=0, error=0, stall_cnt=0; outputs follow REQ-017..024 for HZ_RUN.

Structure
REQ-028 hz_state_e enum and MD_TIMEOUT=63 constant SHALL live in control_pkg.
REQ-029 Combinational LU/BX/BL detection SHALL be a sub-module hazard_detect; FSM, watchdog, counter in hazard_ctrl.

Verification
REQ-030 LU: id_ex_mem_read=1, id_ex_rd=5, if_id_rs2=5, id_uses_rs2=1 -> one cycle pc_en=0, id_ex_bubble=1; stall_cnt=1.
REQ-031 Branch after load: cycle1 LU (rd=7, rs1=7, branch); cycle2 BL (ex_mem_rd=7) -> 2 stall cycles, then br_taken=1 gives if_id_flush=1.
REQ-032 rd=0: id_ex_rd=0, rs1=0, id_ex_mem_read=1 -> no stall.
REQ-033 Muldiv: ex_muldiv=1, done after 4 cycles -> HZ_MDWAIT, ex_mem_bubble=1 for 4 cycles, done cycle all enables=1, back to HZ_RUN; stall_cnt=4.
REQ-034 Timeout: ex_muldiv=1, done never -> HZ_ERR after 64 wait cycles, error=1; rst_n low mid-wait in another run -> immediate HZ_RUN, stall_cnt=0.
REQ-035 Saturation: force 70000 stall cycles -> stall_cnt=16'hFFFF.
